// File: rtl/alu_exec_unit.sv
// WISC-15 execute stage: single-cycle ADD/SUB/NAND/XOR,
// bit-serial shifts, result and Z/N/V held until drained.
module alu_exec_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             illegal_op
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1110;
  localparam logic [3:0] OP_SRA  = 4'b1111;

  localparam int MSB = WIDTH - 1;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       op;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_step;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic             accept;
  logic             is_shift;
  logic [3:0]       amt;

  assign amt = b[3:0];
  assign sum = a + b;
  assign dif = a + ~b + WIDTH'(1);

  always_comb begin
    is_shift = 1'b0;
    case (alu_ctrl)
      OP_SLL, OP_SRL, OP_SRA: is_shift = 1'b1;
      default:                is_shift = 1'b0;
    endcase
  end

  always_comb begin
    sh_step = sh;
    case (op)
      OP_SLL:  sh_step = {sh[MSB-1:0], 1'b0};
      OP_SRL:  sh_step = {1'b0, sh[MSB:1]};
      default: sh_step = {sh[MSB], sh[MSB:1]};
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: in_ready = 1'b1;
      SHIFT: begin
        if (cnt == 4'd1)
          state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = in_valid & in_ready;
    // a new op overrides the drain/idle transition
    if (accept) begin
      if (is_shift && amt != 4'd0)
        state_nxt = SHIFT;
      else
        state_nxt = HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op         <= '0;
      cnt        <= '0;
      sh         <= '0;
      result     <= '0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      flag_v     <= 1'b0;
      illegal_op <= 1'b0;
    end else if (accept) begin
      op <= alu_ctrl;
      case (alu_ctrl)
        OP_ADD: begin
          result     <= sum;
          flag_z     <= (sum == '0);
          flag_n     <= sum[MSB];
          flag_v     <= (a[MSB] == b[MSB]) &
                        (sum[MSB] != a[MSB]);
          illegal_op <= 1'b0;
        end
        OP_SUB: begin
          result     <= dif;
          flag_z     <= (dif == '0);
          flag_n     <= dif[MSB];
          flag_v     <= (a[MSB] != b[MSB]) &
                        (dif[MSB] != a[MSB]);
          illegal_op <= 1'b0;
        end
        OP_NAND: begin
          result     <= ~(a & b);
          flag_z     <= ((a & b) == '1);
          illegal_op <= 1'b0;
        end
        OP_XOR: begin
          result     <= a ^ b;
          flag_z     <= (a == b);
          illegal_op <= 1'b0;
        end
        OP_SLL, OP_SRL, OP_SRA: begin
          if (amt == 4'd0) begin
            result     <= a;
            flag_z     <= (a == '0);
            illegal_op <= 1'b0;
          end else begin
            sh  <= a;
            cnt <= amt;
          end
        end
        default: begin
          result     <= '0;
          illegal_op <= 1'b1;
        end
      endcase
    end else if (state == SHIFT) begin
      sh  <= sh_step;
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        result     <= sh_step;
        flag_z     <= (sh_step == '0);
        illegal_op <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed literals plus random
// traffic against a transaction-level model.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  alu_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flag_z;
  logic        flag_n;
  logic        flag_v;
  logic        illegal_op;

  alu_exec_unit #(.WIDTH(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .alu_ctrl(alu_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .flag_z(flag_z),
    .flag_n(flag_n),
    .flag_v(flag_v),
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state
  logic        m_valid;
  logic        m_busy;
  int          m_rem;
  logic [15:0] p_a;
  logic [15:0] p_b;
  logic [3:0]  p_op;
  logic [15:0] m_res;
  logic        m_z;
  logic        m_n;
  logic        m_v;
  logic        m_ill;

  task automatic chk(input string name,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_busy  = 0;
    m_rem   = 0;
    m_res   = 0;
    m_z     = 0;
    m_n     = 0;
    m_v     = 0;
    m_ill   = 0;
  endtask

  function automatic bit shift_op(input logic [3:0] c);
    return c == 4'b1100 || c == 4'b1110 || c == 4'b1111;
  endfunction

  task automatic commit();
    logic [15:0] r;
    int k;
    k = int'(p_b[3:0]);
    r = 0;
    m_ill = 0;
    case (p_op)
      4'b0000: begin
        r = p_a + p_b;
        m_n = r[15];
        m_v = (p_a[15] == p_b[15]) && (r[15] != p_a[15]);
      end
      4'b0001: begin
        r = p_a - p_b;
        m_n = r[15];
        m_v = (p_a[15] != p_b[15]) && (r[15] != p_a[15]);
      end
      4'b0100: r = ~(p_a & p_b);
      4'b1000: r = p_a ^ p_b;
      4'b1100: r = p_a << k;
      4'b1110: r = p_a >> k;
      4'b1111: r = 16'($signed(p_a) >>> k);
      default: m_ill = 1;
    endcase
    m_res = r;
    if (!m_ill) m_z = (r == 0);
  endtask

  task automatic check_outs();
    chk("out_valid", 16'(out_valid), 16'(m_valid));
    chk("result", result, m_res);
    chk("flags", {13'd0, flag_z, flag_n, flag_v},
        {13'd0, m_z, m_n, m_v});
    chk("illegal_op", 16'(illegal_op), 16'(m_ill));
  endtask

  // one clock: drive at negedge, advance model at posedge
  task automatic step(input logic iv,
                      input logic [15:0] ia,
                      input logic [15:0] ib,
                      input logic [3:0] ic,
                      input logic ordy,
                      output logic acc);
    logic rdy;
    int lat;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    alu_ctrl  = ic;
    out_ready = ordy;
    #1;
    rdy = !m_busy && (!m_valid || ordy);
    chk("in_ready", 16'(in_ready), 16'(rdy));
    acc = iv && rdy;
    @(posedge clk);
    if (m_valid && ordy) m_valid = 0;
    if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        commit();
        m_busy  = 0;
        m_valid = 1;
      end
    end
    if (acc) begin
      p_a  = ia;
      p_b  = ib;
      p_op = ic;
      lat  = shift_op(ic) ? 1 + int'(ib[3:0]) : 1;
      if (lat == 1) begin
        commit();
        m_valid = 1;
      end else begin
        m_busy = 1;
        m_rem  = lat - 1;
      end
    end
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(0, 16'h0, 16'h0, 4'h0, ordy, acc);
  endtask

  // issue from idle, wait (bounded) for result, report latency
  task automatic run_op(input logic [15:0] ia,
                        input logic [15:0] ib,
                        input logic [3:0] ic,
                        output int lat);
    logic acc;
    step(1, ia, ib, ic, 0, acc);
    chk("accept", 16'(acc), 16'd1);
    lat = 1;
    while (!out_valid && lat < 40) begin
      idle(0);
      lat++;
    end
    if (!out_valid) begin
      errors++;
      $display("FAIL timeout got=%0d exp=valid", lat);
    end
  endtask

  initial begin
    int lat;
    int lows;
    logic acc;
    rst_n     = 0;
    in_valid  = 0;
    a         = 0;
    b         = 0;
    alu_ctrl  = 0;
    out_ready = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_result", result, 16'h0);
    check_outs();
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", 16'(in_ready), 16'd1);

    run_op(16'h7FFF, 16'h0001, 4'b0000, lat);
    chk("add_lat", 16'(lat), 16'd1);
    chk("add_res", result, 16'h8000);
    chk("add_znv", {flag_z, flag_n, flag_v}, 16'b011);
    idle(1);

    run_op(16'h0000, 16'h0049, 4'b0001, lat);
    chk("sub_res", result, 16'hFFB7);
    chk("sub_nv", {flag_n, flag_v}, 16'b10);
    idle(1);
    run_op(16'hFFFF, 16'hFFFF, 4'b0100, lat);
    chk("nand_res", result, 16'h0000);
    chk("nand_znv", {flag_z, flag_n, flag_v}, 16'b110);
    idle(1);

    lows = 0;
    step(1, 16'h8000, 16'h0004, 4'b1111, 0, acc);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (!in_ready) lows++;
      idle(0);
      lat++;
    end
    chk("sra_lat", 16'(lat), 16'd5);
    chk("sra_res", result, 16'hF800);
    chk("sra_rdy_low", 16'(lows), 16'd4);
    idle(1);

    run_op(16'h8000, 16'h000F, 4'b1110, lat);
    chk("srl_lat", 16'(lat), 16'd16);
    chk("srl_res", result, 16'h0001);
    idle(1);
    run_op(16'h1234, 16'h0010, 4'b1100, lat);
    chk("sll0_lat", 16'(lat), 16'd1);
    chk("sll0_res", result, 16'h1234);
    idle(1);

    run_op(16'h00FF, 16'h0F0F, 4'b1000, lat);
    chk("xor_res", result, 16'h0FF0);
    for (int i = 0; i < 3; i++) begin
      idle(0);
      chk("bp_res", result, 16'h0FF0);
      chk("bp_in_ready", 16'(in_ready), 16'd0);
    end
    step(1, 16'h0001, 16'h0002, 4'b0000, 1, acc);
    chk("b2b_accept", 16'(acc), 16'd1);
    chk("b2b_res", result, 16'h0003);
    idle(1);

    run_op(16'h1111, 16'h2222, 4'b0010, lat);
    chk("ill_lat", 16'(lat), 16'd1);
    chk("ill_res", result, 16'h0000);
    chk("ill_flag", 16'(illegal_op), 16'd1);
    chk("ill_znv", {flag_z, flag_n, flag_v}, 16'b000);
    idle(1);

    step(1, 16'h00FF, 16'h000A, 4'b1100, 0, acc);
    idle(0);
    idle(0);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_ill", 16'(illegal_op), 16'd0);
    chk("mid_rst_res", result, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    run_op(16'h0001, 16'h0001, 4'b0000, lat);
    chk("post_rst_lat", 16'(lat), 16'd1);
    chk("post_rst_res", result, 16'h0002);
    idle(1);

    for (int i = 0; i < 800; i++) begin
      logic [3:0] op;
      logic [15:0] ra;
      logic [15:0] rb;
      case ($urandom_range(0, 7))
        0: op = 4'b0000;
        1: op = 4'b0001;
        2: op = 4'b0100;
        3: op = 4'b1000;
        4: op = 4'b1100;
        5: op = 4'b1110;
        6: op = 4'b1111;
        default: op = 4'($urandom_range(0, 15));
      endcase
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra = {ra[15], 15'h7FFF};
      if ($urandom_range(0, 3) == 0) rb = ra;
      step(1'($urandom_range(0, 1)), ra, rb, op,
           1'($urandom_range(0, 3) != 0), acc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered, handshaked execute stage wrapped around the WISC-15 ALU operation set. It accepts one operation (A, B, alu_ctrl) per transaction, computes ADD/SUB/NAND/XOR in one cycle and shifts iteratively at one bit per cycle. It holds the result and the Z/N/V flag registers until the consumer (writeback/branch logic) takes them. It sits between decode and writeback, giving the processor a multi-cycle execute path with valid/ready flow control.

## Interface
- WIDTH, 16, datapath width; only 16 is supported.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept an operation this cycle
- a  in  16  operand A
- b  in  16  operand B; b[3:0] is the shift amount for shifts
- alu_ctrl  in  4  opcode: 0000 ADD, 0001 SUB, 0100 NAND, 1000 XOR, 1100 SLL, 1110 SRL, 1111 SRA
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  16  registered result
- flag_z, flag_n, flag_v  out  1 each  registered condition flags
- illegal_op  out  1  registered; high with out_valid when the accepted opcode was not listed above

## Operation
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - in_ready = 1.
  - On accept (in_valid & in_ready), capture the opcode.
  - Non-shift op: write result and flags, then go to HOLD.
  - Shift with b[3:0] = 0: result = a, go to HOLD.
  - Shift with b[3:0] = k > 0: load a into the shift register, set count = k, go to SHIFT.
- SHIFT:
  - Each cycle: shift 1 bit (SLL fills 0; SRL fills 0; SRA replicates bit 15) and decrement count.
  - When count reaches 0 after a shift, write result, go to HOLD.
  - in_ready = 0.
- HOLD:
  - out_valid = 1.
  - On out_ready, return to IDLE.
  - in_ready = out_ready, so back-to-back operation is allowed: a new op may be accepted in the same cycle the old result drains, and it is processed as if accepted from IDLE.
- Arithmetic:
  - ADD/SUB are 16-bit with wrap-around (no saturation); carry out is discarded.
  - SUB computes a + ~b + 1.
  - V for ADD = (a[15]==b[15]) & (r[15]!=a[15]).
  - V for SUB = (a[15]!=b[15]) & (r[15]!=a[15]).
- Flag update rules, applied when the result is written:
  - ADD/SUB update Z, N and V.
  - NAND, XOR and shifts update Z only; N and V hold.
  - Z = (result == 0); N = result[15].
- Illegal opcode:
  - result = 0, flags unchanged, illegal_op = 1, go to HOLD with 1-cycle latency.
  - illegal_op clears on the next written result.
- result, illegal_op and the flags are stable while out_valid = 1 and out_ready = 0.
- Reset (asynchronous, any state, including mid-shift):
  - state = IDLE; out_valid = 0; result = 0; flag_z = flag_n = flag_v = 0; illegal_op = 0; count = 0.
  - An in-flight operation is discarded.
  - in_ready = 1 from the first clock edge after rst_n rises.

## Timing
- Accept at edge T:
  - Non-shift and illegal ops: out_valid = 1 after edge T+1.
  - Shift by k: out_valid = 1 after edge T+1+k; maximum k = 15, so latency is 16.
- Flags change on the same edge on which out_valid rises, never at any other time.
- Throughput: one non-shift op per cycle with out_ready held high; shifts by k occupy 1+k cycles.
- in_ready is combinational from state and out_ready only; it never depends on in_valid.
- out_valid does not drop without out_ready.

## Test plan
- ADD a=7FFF, b=0001 -> result 8000, z=0 n=1 v=1, out_valid one cycle after accept.
- SUB a=0000, b=0049 -> result FFB7, n=1 v=0. Then NAND a=FFFF, b=FFFF -> result 0000, z=1, n stays 1, v stays 0.
- SRA a=8000, b=0004 -> result F800 after 5 cycles, in_ready low for 4 cycles. SRL a=8000, b=000F -> 0001 after 16 cycles. SLL with b=0010 (k=0) -> result = a after 1 cycle.
- Backpressure: XOR a=00FF, b=0F0F -> 0FF0, out_ready held low 3 cycles. Result and flags stable, in_ready=0. On out_ready=1 with a new in_valid, the new op is accepted in the same cycle.
- Illegal opcode 0010 -> out_valid after 1 cycle, result 0000, illegal_op=1, flags unchanged.
- Assert rst_n low on the 3rd cycle of a 10-bit shift -> outputs 0 immediately, out_valid=0. After release, ADD 0001+0001 -> 0002 with normal latency.
